// File: rtl/ram_bus_master_pkg.sv
// Widths shared between the RAM bus master and the RAM instance.
// Parameter defaults of the master and its interface derive from these.
package ram_bus_master_pkg;

    localparam int RAM_ADDR_BUS = 8;
    localparam int RAM_DATA_BUS = 64;
    localparam int RAM_SIZE_BUS = 1 << RAM_ADDR_BUS;
    localparam logic [RAM_DATA_BUS-1:0] RAM_DATA_HZ = {RAM_DATA_BUS{1'bz}};

endpackage

// File: rtl/ram_bus_master_if.sv
// Core-side request/response handshake plus the registered RAM control lines.
// The tri-stated data line is kept off the interface and wired directly.
interface ram_bus_master_if
    import ram_bus_master_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_BUS,
    parameter int DATA_WIDTH = RAM_DATA_BUS
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    logic [ADDR_WIDTH-1:0] bus_addr;
    logic                  bus_wr_en;
    logic                  bus_rd_en;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, bus_addr, bus_wr_en, bus_rd_en
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, bus_addr, bus_wr_en, bus_rd_en
    );

endinterface

// File: rtl/ram_bus_io.sv
// Tri-state pad for the shared RAM data line; combinational in both directions.
// The line floats whenever drive_en is low so the RAM may drive it.
module ram_bus_io
    import ram_bus_master_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_BUS
) (
    input  logic                  drive_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    inout  wire  [DATA_WIDTH-1:0] bus_data
);

    assign bus_data = drive_en ? wdata : {DATA_WIDTH{1'bz}};
    assign rdata    = bus_data;

endmodule

// File: rtl/ram_bus_master.sv
// Single-port RAM initiator: writes take 2 cycles, reads return rsp_valid 2 edges after accept.
// One request at a time; req_ready only in IDLE, RESP holds until rsp_ready.
module ram_bus_master
    import ram_bus_master_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_BUS,
    parameter int DATA_WIDTH = RAM_DATA_BUS
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_bus_master_if.master      mif,
    inout  wire  [DATA_WIDTH-1:0] bus_data
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  drive_en;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic                  wr_en_q;
    logic                  rd_en_q;
    logic [DATA_WIDTH-1:0] bus_in;

    // drive_en only rises with wr_en and both drop together, so the pad can
    // never overlap a RAM read cycle; RESP provides the turnaround gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            drive_en    <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mif.req_valid) begin
                        addr_q      <= mif.req_addr;
                        wdata_q     <= mif.req_wdata;
                        req_ready_q <= 1'b0;
                        if (mif.req_we) begin
                            state    <= WRITE;
                            wr_en_q  <= 1'b1;
                            drive_en <= 1'b1;
                        end else begin
                            state   <= RD_ADDR;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state       <= IDLE;
                    wr_en_q     <= 1'b0;
                    drive_en    <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                RD_ADDR: begin
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    state       <= RESP;
                    rdata_q     <= bus_in;
                    rd_en_q     <= 1'b0;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (mif.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    drive_en    <= 1'b0;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    wr_en_q     <= 1'b0;
                    rd_en_q     <= 1'b0;
                end
            endcase
        end
    end

    assign mif.req_ready = req_ready_q;
    assign mif.rsp_valid = rsp_valid_q;
    assign mif.rsp_rdata = rdata_q;
    assign mif.bus_addr  = addr_q;
    assign mif.bus_wr_en = wr_en_q;
    assign mif.bus_rd_en = rd_en_q;

    ram_bus_io #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_io (
        .drive_en (drive_en),
        .wdata    (wdata_q),
        .rdata    (bus_in),
        .bus_data (bus_data)
    );

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: a registered RAM on the shared line, a transaction-level
// expectation model, a per-cycle compare on the falling edge, directed and random traffic.
module tb_ram_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    wire  [63:0] bus_data;

    ram_bus_master_if mif ();

    ram_bus_master dut (
        .clk      (clk),
        .rst      (rst),
        .mif      (mif),
        .bus_data (bus_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pat(input int i);
        return {32'hA5A50000 + 32'(i), 32'(i) * 32'h01010101};
    endfunction

    // RAM: registers mem[addr] on a read edge and drives it while the read continues
    logic [63:0] ram_mem [256];
    logic [63:0] ram_q = '0;
    logic        ram_oe_q = 1'b0;
    assign bus_data = (mif.bus_rd_en && ram_oe_q) ? ram_q : 64'bz;

    always @(posedge clk) begin
        if (mif.bus_wr_en) ram_mem[mif.bus_addr] <= bus_data;
        if (mif.bus_rd_en) ram_q <= ram_mem[mif.bus_addr];
        ram_oe_q <= mif.bus_rd_en;
    end

    // Expectation model: one transaction in flight, tracked by cycles since accept
    logic [63:0] m_mem [256];
    bit          m_busy  = 1'b0;
    bit          m_we    = 1'b0;
    int          m_age   = 0;
    logic [7:0]  m_addr  = '0;
    logic [63:0] m_wdata = '0;
    logic [63:0] m_rdata = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_age   <= 0;
            m_rdata <= '0;
        end else if (!m_busy) begin
            if (mif.req_valid) begin
                m_busy  <= 1'b1;
                m_we    <= mif.req_we;
                m_age   <= 1;
                m_addr  <= mif.req_addr;
                m_wdata <= mif.req_wdata;
            end
        end else begin
            m_age <= m_age + 1;
            if (m_we) begin
                m_mem[m_addr] <= m_wdata;
                m_busy        <= 1'b0;
            end else if (m_age == 2) begin
                m_rdata <= m_mem[m_addr];
            end else if (m_age >= 3 && mif.rsp_ready) begin
                m_busy <= 1'b0;
            end
        end
    end

    logic [63:0] rsp_q [$];
    bit          prev_rd = 1'b0;

    always @(negedge clk) begin
        bit exp_wr, exp_rd, exp_vld;
        exp_wr  = m_busy && m_we && (m_age == 1);
        exp_rd  = m_busy && !m_we && (m_age == 1 || m_age == 2);
        exp_vld = m_busy && !m_we && (m_age >= 3);
        chk("req_ready", 64'(mif.req_ready), 64'(!m_busy));
        chk("bus_wr_en", 64'(mif.bus_wr_en), 64'(exp_wr));
        chk("bus_rd_en", 64'(mif.bus_rd_en), 64'(exp_rd));
        chk("rsp_valid", 64'(mif.rsp_valid), 64'(exp_vld));
        chk("rsp_rdata", mif.rsp_rdata, m_rdata);
        chk("drive_en", 64'(dut.drive_en), 64'(exp_wr));
        chk("drive_vs_rd", 64'(dut.drive_en & mif.bus_rd_en), 64'd0);
        chk("turnaround", 64'(prev_rd & mif.bus_wr_en), 64'd0);
        if (exp_wr) begin
            chk("wr_addr", 64'(mif.bus_addr), 64'(m_addr));
            chk("wr_data", bus_data, m_wdata);
        end
        if (exp_rd) chk("rd_addr", 64'(mif.bus_addr), 64'(m_addr));
        if (mif.rsp_valid && mif.rsp_ready) rsp_q.push_back(mif.rsp_rdata);
        prev_rd = mif.bus_rd_en;
    end

    task automatic issue(input bit we, input logic [7:0] a, input logic [63:0] d, output int fcyc);
        mif.req_valid = 1'b1;
        mif.req_we    = we;
        mif.req_addr  = a;
        mif.req_wdata = d;
        fcyc = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (mif.req_ready) begin
                fcyc = cyc;
                @(posedge clk);
                #1;
                break;
            end
        end
        if (fcyc < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: request to addr 0x%02h never accepted", a);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    bit rand_mode = 1'b0;

    initial begin
        int f0, f1, f2, f3;
        int n_rsp, n_vld;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = pat(i);
            m_mem[i]   = pat(i);
        end
        mif.req_valid = 1'b0;
        mif.req_we    = 1'b0;
        mif.req_addr  = '0;
        mif.req_wdata = '0;
        mif.rsp_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_req_ready", 64'(mif.req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(mif.rsp_valid), 64'd0);
        chk("rst_rsp_rdata", mif.rsp_rdata, 64'd0);
        chk("rst_bus_addr", 64'(mif.bus_addr), 64'd0);
        chk("rst_enables", 64'({mif.bus_wr_en, mif.bus_rd_en, dut.drive_en}), 64'd0);

        // single write then read-back
        issue(1'b1, 8'h05, 64'h0123_4567_89AB_CDEF, f0);
        mif.req_valid = 1'b0;
        @(negedge clk);
        chk("w5_wr_en", 64'(mif.bus_wr_en), 64'd1);
        chk("w5_data", bus_data, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        chk("w5_wr_en_drop", 64'(mif.bus_wr_en), 64'd0);
        issue(1'b0, 8'h05, 64'd0, f0);
        mif.req_valid = 1'b0;
        @(negedge clk);
        chk("r5_vld_e1", 64'(mif.rsp_valid), 64'd0);
        @(negedge clk);
        chk("r5_vld_e2", 64'(mif.rsp_valid), 64'd0);
        @(negedge clk);
        chk("r5_vld_e3", 64'(mif.rsp_valid), 64'd1);
        chk("r5_rdata", mif.rsp_rdata, 64'h0123_4567_89AB_CDEF);
        step();

        // back-to-back with req_valid held
        rsp_q.delete();
        issue(1'b1, 8'h01, 64'h11, f0);
        issue(1'b1, 8'h02, 64'h22, f1);
        issue(1'b0, 8'h01, 64'd0, f2);
        issue(1'b0, 8'h02, 64'd0, f3);
        mif.req_valid = 1'b0;
        repeat (6) step();
        chk("b2b_w_gap", 64'(f1 - f0), 64'd2);
        chk("b2b_w2r_gap", 64'(f2 - f1), 64'd2);
        chk("b2b_r_gap", 64'(f3 - f2), 64'd4);
        n_rsp = rsp_q.size();
        chk("b2b_rsp_cnt", 64'(n_rsp), 64'd2);
        if (n_rsp == 2) begin
            chk("b2b_rsp0", rsp_q[0], 64'h11);
            chk("b2b_rsp1", rsp_q[1], 64'h22);
        end

        // response backpressure with a competing request held
        issue(1'b1, 8'h07, 64'hAA, f0);
        mif.rsp_ready = 1'b0;
        issue(1'b0, 8'h07, 64'd0, f0);
        mif.req_valid = 1'b1;
        mif.req_we    = 1'b1;
        mif.req_addr  = 8'h09;
        mif.req_wdata = 64'h99;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 64'(mif.rsp_valid), 64'd1);
            chk("bp_rsp_rdata", mif.rsp_rdata, 64'hAA);
            chk("bp_rd_en", 64'(mif.bus_rd_en), 64'd0);
            chk("bp_req_ready", 64'(mif.req_ready), 64'd0);
        end
        #1;
        mif.rsp_ready = 1'b1;
        issue(1'b1, 8'h09, 64'h99, f1);
        chk("bp_release_gap", 64'(f1 - f0), 64'd8);
        mif.req_valid = 1'b0;
        step();

        // reset pulsed during RD_DATA
        issue(1'b0, 8'h03, 64'd0, f0);
        mif.req_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("rd_data_rd_en", 64'(mif.bus_rd_en), 64'd1);
        rst = 1'b1;
        #1;
        chk("arst_rd_en", 64'(mif.bus_rd_en), 64'd0);
        chk("arst_rsp_valid", 64'(mif.rsp_valid), 64'd0);
        chk("arst_drive", 64'(dut.drive_en), 64'd0);
        step();
        rst = 1'b0;
        n_vld = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mif.rsp_valid) n_vld++;
        end
        chk("arst_no_rsp", 64'(n_vld), 64'd0);
        chk("arst_req_ready", 64'(mif.req_ready), 64'd1);

        // read immediately followed by write
        step();
        issue(1'b0, 8'h01, 64'd0, f0);
        issue(1'b1, 8'h04, 64'h44, f1);
        mif.req_valid = 1'b0;
        chk("r2w_gap", 64'(f1 - f0), 64'd4);
        step();

        // idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_quiet", 64'({mif.bus_wr_en, mif.bus_rd_en, dut.drive_en, mif.rsp_valid}), 64'd0);
        end

        // random traffic, random response backpressure
        rand_mode = 1'b1;
        fork
            begin
                while (rand_mode) begin
                    step();
                    mif.rsp_ready = ($urandom_range(0, 2) != 0);
                end
                mif.rsp_ready = 1'b1;
            end
        join_none
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) step();
            issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), {$urandom, $urandom}, f0);
            mif.req_valid = 1'b0;
        end
        rand_mode = 1'b0;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_bus_master.md
Name: ram_bus_master

Overview:
Initiator for the shared single-port RAM bus: addr, wr_en, rd_en and a bidirectional tri-stated data line. It accepts word read/write requests from a core-side valid/ready interface and sequences the RAM's cycle timing. It owns bus turnaround so the data line never has two drivers. It sits between the core's load/store path and the ram instance.

Parameters:
ADDR_WIDTH, 8, RAM word-address width; must match RAM depth.
DATA_WIDTH, 64, RAM word width.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  master can accept a request; high only in IDLE
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  word address
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  read data valid; held until accepted
rsp_ready  input  1  core accepts read data
rsp_rdata  output  DATA_WIDTH  read data
bus_addr  output  ADDR_WIDTH  RAM address, registered
bus_wr_en  output  1  RAM write enable, registered
bus_rd_en  output  1  RAM read enable, registered
bus_data  inout  DATA_WIDTH  shared data line; driven only in WRITE, else high-Z

Behaviour:
- Reset (async, immediate):
  - State IDLE; bus_addr=0, bus_wr_en=0, bus_rd_en=0.
  - Drive enable=0, so bus_data is high-Z at once.
  - rsp_valid=0, rsp_rdata=0, req_ready=1 after reset releases.
- Reset mid-operation aborts the transaction. No response is issued for an aborted read. A write aborted before its edge is not guaranteed to land.
- Request fire = req_valid & req_ready. Fields are captured at the fire edge; inputs are don't-care afterwards.
- FSM states: IDLE, WRITE, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - req_ready=1; all bus enables 0; bus released.
  - Fire with req_we=1 -> WRITE.
  - Fire with req_we=0 -> RD_ADDR.
- WRITE (1 cycle):
  - bus_wr_en=1, bus_addr=captured address.
  - Drive enable=1, bus_data=captured wdata.
  - RAM stores at the closing edge; next state IDLE.
  - Write occupancy is 2 cycles per request (accept + WRITE).
- RD_ADDR (1 cycle):
  - bus_rd_en=1, bus_addr held.
  - RAM registers mem[addr] at the closing edge; next state RD_DATA.
- RD_DATA (1 cycle):
  - bus_rd_en=1, address held; RAM drives bus_data.
  - Master samples bus_data into rsp_rdata at the closing edge; next state RESP.
- RESP:
  - rsp_valid=1; rsp_rdata stable; bus_rd_en=0; bus released.
  - Stays in RESP while rsp_ready=0.
  - On rsp_ready=1: rsp_valid falls at that edge; next state IDLE.
- Read latency: fire edge E0 -> rsp_valid high from E2. Minimum read occupancy is 4 cycles including IDLE.
- Turnaround:
  - RESP always spends at least one cycle with rd_en=0 before any later WRITE can drive.
  - Drive enable and bus_rd_en are never 1 in the same cycle. This is an invariant.
- bus_wr_en and bus_rd_en are mutually exclusive at all times.
- rsp_rdata keeps its last value outside RESP. It changes only at the RD_DATA closing edge.
- No address range checking; addresses wrap at the width naturally.
- req_valid during a non-IDLE state is ignored (req_ready=0). No queueing.

Decomposition:
- Shared defines.v: RAM_ADDR_BUS, RAM_DATA_BUS, RAM_DATA_HZ, RAM_SIZE_BUS widths/constants (shared with ram). Parameter defaults derive from them.
- FSM state encodings stay local parameters.
- One sub-module is natural: ram_bus_io. It holds the tri-state driver: bus_data = drive_en ? wdata : high-Z, and returns bus_data as the sampled input.

Test Plan:
- After reset, write 0x0123_4567_89AB_CDEF to addr 0x05:
  - bus_wr_en high exactly one cycle; bus_data equals the value in that cycle.
  - Then read addr 0x05 -> rsp_valid 2 edges after fire; rsp_rdata=0x0123_4567_89AB_CDEF.
- Back-to-back: write addr 1=0x11, write addr 2=0x22, read 1, read 2 with req_valid held high:
  - req_ready pattern matches 2-cycle writes / 4-cycle reads.
  - Responses 0x11 then 0x22.
- Response backpressure: hold rsp_ready=0 for 5 cycles during a read of 0xAA:
  - rsp_valid and rsp_rdata=0xAA stay stable.
  - bus_rd_en=0 throughout RESP; no new request accepted.
- Reset pulsed during RD_DATA:
  - bus_rd_en, rsp_valid and drive drop immediately (async); bus_data goes high-Z.
  - No response afterwards; req_ready=1 after release.
- Read immediately followed by write (req_valid held):
  - Assertion passes: never drive_en && bus_rd_en.
  - At least one cycle with both enables 0 between the last rd_en cycle and the write-drive cycle.
- Idle for 10 cycles with req_valid=0: bus_data is all-Z; all bus enables 0; rsp_valid 0.
